interval_timer_bank: RTL and testbench

INTERVAL_TIMER_BANK -- requirements
Module: interval_timer_bank

---
 rtl/interval_timer_pkg.sv | 14 +
 rtl/interval_timer_ch.sv | 93 +++++++++
 rtl/interval_timer_bank.sv | 52 +++++
 tb/tb_interval_timer_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the interval timer bank.
// Optional capture path: define INTERVAL_TIMER_CAPTURE_EN.
package interval_timer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NUM_CH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/interval_timer_ch.sv
// One timer channel: IDLE/RUN/DONE FSM with count and expire pulse.
// Optional capture path: define INTERVAL_TIMER_CAPTURE_EN.
module interval_timer_ch
  import interval_timer_pkg::*;
#(
  parameter int W        = DEF_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         en_i,
  input  logic         start_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] period_i,
  output logic [W-1:0] count_o,
  output logic         running_o,
  output logic         expire_o
`ifdef INTERVAL_TIMER_CAPTURE_EN
  ,
  output logic [W-1:0] capture_o,
  output logic         capture_valid_o
`endif
);

  localparam logic [W-1:0] ONE = W'(1);

  ch_state_e    state_q;
  logic [W-1:0] count_q;
  logic         running_q;
  logic         expire_q;

  // Channel FSM: start beats load beats en-gated counting.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      expire_q  <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      if (start_i) begin
        count_q   <= ONE;
        state_q   <= ST_RUN;
        running_q <= 1'b1;
      end else if (load_i) begin
        count_q   <= value_i;
        state_q   <= ST_RUN;
        running_q <= 1'b1;
      end else if (en_i && state_q == ST_RUN) begin
        if (count_q < period_i) begin
          count_q <= count_q + ONE;
        end else begin
          expire_q <= 1'b1;
          if (SATURATE != 0) begin
            count_q   <= period_i;
            state_q   <= ST_DONE;
            running_q <= 1'b0;
          end else begin
            count_q <= '0;
          end
        end
      end
    end
  end

  assign count_o   = count_q;
  assign running_o = running_q;
  assign expire_o  = expire_q;

`ifdef INTERVAL_TIMER_CAPTURE_EN
  logic [W-1:0] capture_q;
  logic         cap_vld_q;

  // Snapshot the live count when a running channel is restarted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      capture_q <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= 1'b0;
      if (start_i && state_q == ST_RUN) begin
        capture_q <= count_q;
        cap_vld_q <= 1'b1;
      end
    end
  end

  assign capture_o       = capture_q;
  assign capture_valid_o = cap_vld_q;
`endif

endmodule

// File: rtl/interval_timer_bank.sv
// Bank of NUM_CH independent interval timers sharing one enable.
// Optional capture path: define INTERVAL_TIMER_CAPTURE_EN.
module interval_timer_bank
  import interval_timer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int SATURATE   = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH-1:0]            load,
  input  logic [NUM_CH*DATA_WIDTH-1:0] value,
  input  logic [NUM_CH*DATA_WIDTH-1:0] period,
  output logic [NUM_CH*DATA_WIDTH-1:0] counter_val,
  output logic [NUM_CH-1:0]            running,
  output logic [NUM_CH-1:0]            expire
`ifdef INTERVAL_TIMER_CAPTURE_EN
  ,
  output logic [NUM_CH*DATA_WIDTH-1:0] capture,
  output logic [NUM_CH-1:0]            capture_valid
`endif
);

  localparam int W = DATA_WIDTH;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    interval_timer_ch #(
      .W        (W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk_i           (clk),
      .rstn_i          (rstn),
      .en_i            (en),
      .start_i         (start[k]),
      .load_i          (load[k]),
      .value_i         (value[k*W +: W]),
      .period_i        (period[k*W +: W]),
      .count_o         (counter_val[k*W +: W]),
      .running_o       (running[k]),
      .expire_o        (expire[k])
`ifdef INTERVAL_TIMER_CAPTURE_EN
      ,
      .capture_o       (capture[k*W +: W]),
      .capture_valid_o (capture_valid[k])
`endif
    );
  end

endmodule

// File: tb/tb_interval_timer_bank.sv
// Scoreboard bench: wrap and saturate banks against a cycle model.
// Capture checks active when INTERVAL_TIMER_CAPTURE_EN is defined.
module tb_interval_timer_bank;

  localparam int W = 16;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic [N-1:0] start = '0;
  logic [N-1:0] load = '0;
  logic [N*W-1:0] value = '0;
  logic [N*W-1:0] period = '0;

  logic [N*W-1:0] cv0, cv1;
  logic [N-1:0] run0, run1, exp0, exp1;
`ifdef INTERVAL_TIMER_CAPTURE_EN
  logic [N*W-1:0] cap0, cap1;
  logic [N-1:0] capv0, capv1;
`endif

  always #5 clk = ~clk;

  interval_timer_bank #(.DATA_WIDTH(W), .NUM_CH(N), .SATURATE(0)) u_wrap (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .load(load),
    .value(value), .period(period), .counter_val(cv0),
    .running(run0), .expire(exp0)
`ifdef INTERVAL_TIMER_CAPTURE_EN
    , .capture(cap0), .capture_valid(capv0)
`endif
  );

  interval_timer_bank #(.DATA_WIDTH(W), .NUM_CH(N), .SATURATE(1)) u_sat (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .load(load),
    .value(value), .period(period), .counter_val(cv1),
    .running(run1), .expire(exp1)
`ifdef INTERVAL_TIMER_CAPTURE_EN
    , .capture(cap1), .capture_valid(capv1)
`endif
  );

  typedef struct {
    logic [1:0][N*W-1:0] cv;
    logic [1:0][N-1:0]   run;
    logic [1:0][N-1:0]   exp;
    logic [1:0][N*W-1:0] cap;
    logic [1:0][N-1:0]   capv;
  } exp_t;

  exp_t q[$];

  // Model: mode 0 idle, 1 running, 2 finished (saturating only).
  int  m_cnt  [2][N];
  int  m_mode [2][N];
  bit  m_exp  [2][N];
  int  m_cap  [2][N];
  bit  m_capv [2][N];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < N; k++) begin
        m_cnt[s][k] = 0; m_mode[s][k] = 0; m_exp[s][k] = 0;
        m_cap[s][k] = 0; m_capv[s][k] = 0;
      end
  endfunction

  function automatic void model_step();
    exp_t e;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < N; k++) begin
        int p;
        int v;
        p = int'(period[k*W +: W]);
        v = int'(value[k*W +: W]);
        m_exp[s][k] = 0;
        m_capv[s][k] = 0;
        if (start[k]) begin
          if (m_mode[s][k] == 1) begin
            m_cap[s][k] = m_cnt[s][k];
            m_capv[s][k] = 1;
          end
          m_cnt[s][k] = 1;
          m_mode[s][k] = 1;
        end else if (load[k]) begin
          m_cnt[s][k] = v;
          m_mode[s][k] = 1;
        end else if (en && m_mode[s][k] == 1) begin
          if (m_cnt[s][k] < p) m_cnt[s][k] = m_cnt[s][k] + 1;
          else begin
            m_exp[s][k] = 1;
            if (s == 1) begin
              m_cnt[s][k] = p;
              m_mode[s][k] = 2;
            end else m_cnt[s][k] = 0;
          end
        end
        e.cv[s][k*W +: W]  = W'(m_cnt[s][k]);
        e.run[s][k]        = (m_mode[s][k] == 1);
        e.exp[s][k]        = m_exp[s][k];
        e.cap[s][k*W +: W] = W'(m_cap[s][k]);
        e.capv[s][k]       = m_capv[s][k];
      end
    q.push_back(e);
  endfunction

  task automatic step(input logic e, input logic [N-1:0] st,
                      input logic [N-1:0] ld, input logic [N*W-1:0] val,
                      input logic [N*W-1:0] per);
    @(negedge clk);
    en = e; start = st; load = ld; value = val; period = per;
    model_step();
  endtask

  task automatic idle_steps(input int n, input logic e, input logic [N*W-1:0] per);
    for (int i = 0; i < n; i++) step(e, '0, '0, '0, per);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rstn = 1'b0;
    start = '0;
    load = '0;
    #1;
    chk("rst_cv_wrap", 64'(cv0), 64'd0);
    chk("rst_cv_sat", 64'(cv1), 64'd0);
    chk("rst_run", 64'({run0, run1}), 64'd0);
    chk("rst_exp", 64'({exp0, exp1}), 64'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: every cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cv_wrap", 64'(cv0), 64'(e.cv[0]));
        chk("cv_sat", 64'(cv1), 64'(e.cv[1]));
        chk("run_wrap", 64'(run0), 64'(e.run[0]));
        chk("run_sat", 64'(run1), 64'(e.run[1]));
        chk("exp_wrap", 64'(exp0), 64'(e.exp[0]));
        chk("exp_sat", 64'(exp1), 64'(e.exp[1]));
`ifdef INTERVAL_TIMER_CAPTURE_EN
        chk("capv_wrap", 64'(capv0), 64'(e.capv[0]));
        chk("capv_sat", 64'(capv1), 64'(e.capv[1]));
        chk("cap_wrap", 64'(cap0), 64'(e.cap[0]));
        chk("cap_sat", 64'(cap1), 64'(e.cap[1]));
`endif
      end
    end
  end

  initial begin
    logic [N*W-1:0] per;
    logic [N*W-1:0] val;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_cv", 64'({cv0, cv1}), 64'd0);
    chk("reset_run", 64'({run0, run1}), 64'd0);
    rstn = 1'b1;

    // Wrap at period 3: 1,2,3,0,1 with expire on the 0.
    per = {16'd5, 16'd3};
    step(1'b1, 2'b01, '0, '0, per);
    idle_steps(3, 1'b1, per);
    after_edge();
    chk("wrap_zero", 64'(cv0[W-1:0]), 64'd0);
    chk("wrap_exp", 64'(exp0[0]), 64'd1);
    idle_steps(1, 1'b1, per);
    after_edge();
    chk("wrap_one", 64'(cv0[W-1:0]), 64'd1);

    // Saturate at period 4, then idle long enough to see no re-expire.
    do_reset();
    per = {16'd4, 16'd4};
    step(1'b1, 2'b01, '0, '0, per);
    idle_steps(14, 1'b1, per);
    after_edge();
    chk("sat_hold", 64'(cv1[W-1:0]), 64'd4);
    chk("sat_run", 64'(run1[0]), 64'd0);

    // start beats load; lone load past period expires next cycle.
    per = {16'd5, 16'd5};
    val = {16'd9, 16'd9};
    step(1'b1, 2'b01, 2'b01, val, per);
    after_edge();
    chk("start_wins", 64'(cv0[W-1:0]), 64'd1);
    step(1'b1, '0, 2'b01, val, per);
    idle_steps(1, 1'b1, per);
    after_edge();
    chk("load_exp_cnt", 64'(cv0[W-1:0]), 64'd0);
    chk("load_exp", 64'(exp0[0]), 64'd1);

    // Enable paused at count 2 for five cycles.
    per = {16'd10, 16'd10};
    step(1'b1, 2'b01, '0, '0, per);
    idle_steps(1, 1'b1, per);
    idle_steps(5, 1'b0, per);
    after_edge();
    chk("pause_hold", 64'(cv0[W-1:0]), 64'd2);
    idle_steps(1, 1'b1, per);
    after_edge();
    chk("pause_resume", 64'(cv0[W-1:0]), 64'd3);

    // Restart while running at 250, then start from idle.
    per = {16'd300, 16'd300};
    step(1'b1, '0, 2'b01, {16'd0, 16'd250}, per);
    step(1'b1, 2'b01, '0, '0, per);
    after_edge();
    chk("restart_cnt", 64'(cv0[W-1:0]), 64'd1);
    do_reset();
    step(1'b1, 2'b11, '0, '0, per);

    // Mid-count async reset with ch0=7, ch1=3.
    per = {16'd20, 16'd20};
    step(1'b0, '0, 2'b11, {16'd3, 16'd7}, per);
    after_edge();
    chk("pre_rst_cv", 64'(cv0), 64'({16'd3, 16'd7}));
    do_reset();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] st, ld;
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int k = 0; k < N; k++) begin
        st[k] = ($urandom_range(0, 15) == 0);
        ld[k] = ($urandom_range(0, 15) == 0);
        per[k*W +: W] = W'($urandom_range(0, 6));
        val[k*W +: W] = W'($urandom_range(0, 8));
      end
      step($urandom_range(0, 4) != 0, st, ld, val, per);
    end

    after_edge();
    after_edge();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
